truth_table_lut_seq: RTL and testbench

- Programmable, registered N-input truth-table evaluator; successor to the fixed 3-input combinational truth-table blocks.
- Loads the table serially, then evaluates it from a live input vector.
- A built-in sweep mode steps through all 2^N_IN input combinations, captures every output and counts the rows equal to 1.
- Used as a reusable logic cell and self-check engine in the combinational-logic exercises.

---
 rtl/truth_table_pkg.sv | 12 +
 rtl/truth_table_lut_seq_cfg_shifter.sv | 45 ++++
 rtl/truth_table_lut_seq.sv | 109 ++++++++++
 tb/tb_truth_table_lut_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared FSM encoding and table depth for the truth-table evaluator
package truth_table_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int depth_of(input int n_in);
        return 1 << n_in;
    endfunction
endpackage

// File: rtl/truth_table_lut_seq_cfg_shifter.sv
// tt_cfg_shifter: serial table load with load counter and valid flag, frozen during sweep
module tt_cfg_shifter
    import truth_table_pkg::*;
#(
    parameter  int N_IN  = 3,
    localparam int DEPTH = depth_of(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             cfg_en,
    input  logic             cfg_bit,
    output logic [DEPTH-1:0] tbl,
    output logic             cfg_valid
);
    logic [DEPTH-1:0] tbl_q, tbl_d;
    logic [N_IN-1:0]  cnt_q, cnt_d;
    logic             valid_q, valid_d;

    always_comb begin
        tbl_d   = tbl_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (cfg_en && !freeze) begin
            tbl_d   = (DEPTH > 1) ? {cfg_bit, tbl_q[DEPTH-1:1]} : cfg_bit;
            cnt_d   = cnt_q + 1'b1;
            valid_d = &cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            tbl_q   <= tbl_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign tbl       = tbl_q;
    assign cfg_valid = valid_q;
endmodule

// File: rtl/truth_table_lut_seq.sv
// truth_table_lut_seq: programmable registered truth table with exhaustive sweep and ones count
module truth_table_lut_seq
    import truth_table_pkg::*;
#(
    parameter  int N_IN       = 3,
    parameter  int SWEEP_HOLD = 1,
    localparam int DEPTH      = depth_of(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic             cfg_bit,
    output logic             cfg_valid,
    input  logic [N_IN-1:0]  in_vec,
    output logic             y,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [N_IN-1:0]  sweep_idx,
    output logic [DEPTH-1:0] tt_result,
    output logic [N_IN:0]    ones_count
);
    localparam int HW = (SWEEP_HOLD > 1) ? $clog2(SWEEP_HOLD) : 1;

    logic [DEPTH-1:0] tbl;
    state_t           state_q, state_d;
    logic             y_q, y_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [DEPTH-1:0] res_q, res_d;
    logic [N_IN:0]    ones_q, ones_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    tt_cfg_shifter #(.N_IN(N_IN)) u_cfg (
        .clk       (clk),
        .rst_n     (rst_n),
        .freeze    (busy_q),
        .cfg_en    (cfg_en),
        .cfg_bit   (cfg_bit),
        .tbl       (tbl),
        .cfg_valid (cfg_valid)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        res_d   = res_q;
        ones_d  = ones_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q == SWEEP) begin
            y_d = tbl[idx_q];
            if (hold_q == HW'(SWEEP_HOLD - 1)) begin
                res_d[idx_q] = tbl[idx_q];
                ones_d       = ones_q + {{N_IN{1'b0}}, tbl[idx_q]};
                hold_d       = '0;
                idx_d        = idx_q + 1'b1;
                state_d      = (&idx_q) ? DONE : SWEEP;
                busy_d       = !(&idx_q);
                done_d       = &idx_q;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end else begin
            y_d     = tbl[in_vec];
            state_d = IDLE;
            if (state_q == IDLE && sweep_start && cfg_valid && !cfg_en) begin
                state_d = SWEEP;
                busy_d  = 1'b1;
                idx_d   = '0;
                hold_d  = '0;
                res_d   = '0;
                ones_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= 1'b0;
            idx_q   <= '0;
            hold_q  <= '0;
            res_q   <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            res_q   <= res_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y          = y_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;
    assign sweep_idx  = idx_q;
    assign tt_result  = res_q;
    assign ones_count = ones_q;
endmodule

// File: tb/tb_truth_table_lut_seq.sv
// tb_truth_table_lut_seq: two instances (hold 1 and 3) checked each cycle against a behavioural model
module tb_truth_table_lut_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_en = 1'b0;
    logic       cfg_bit = 1'b0;
    logic [2:0] in_vec = '0;
    logic       sweep_start = 1'b0;

    logic [1:0]      valid_o, y_o, busy_o, done_o;
    logic [1:0][2:0] idx_o;
    logic [1:0][7:0] res_o;
    logic [1:0][3:0] ones_o;

    int  n_chk = 0;
    int  n_pass = 0;
    bit  chk_en = 1'b0;

    bit [7:0] m_tbl[2];
    bit [7:0] m_res[2];
    int       m_cnt[2];
    int       m_st[2];
    int       m_k[2];
    bit       m_valid[2];
    bit       m_y[2];

    always #5 clk = ~clk;

    truth_table_lut_seq #(.N_IN(3), .SWEEP_HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_bit(cfg_bit),
        .cfg_valid(valid_o[0]), .in_vec(in_vec), .y(y_o[0]),
        .sweep_start(sweep_start), .sweep_busy(busy_o[0]), .sweep_done(done_o[0]),
        .sweep_idx(idx_o[0]), .tt_result(res_o[0]), .ones_count(ones_o[0])
    );

    truth_table_lut_seq #(.N_IN(3), .SWEEP_HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_bit(cfg_bit),
        .cfg_valid(valid_o[1]), .in_vec(in_vec), .y(y_o[1]),
        .sweep_start(sweep_start), .sweep_busy(busy_o[1]), .sweep_done(done_o[1]),
        .sweep_idx(idx_o[1]), .tt_result(res_o[1]), .ones_count(ones_o[1])
    );

    function automatic int hold_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string nm, input int i, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[inst%0d] got %0h want %0h at %0t", nm, i, act, exp, $time);
    endtask

    // Model: sweep position is a flat cycle count k; row = k / hold, capture on the last hold cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit [7:0] t, r;
            int c, s, k, h;
            bit v, yy, go;
            t = m_tbl[i]; r = m_res[i]; c = m_cnt[i]; s = m_st[i];
            k = m_k[i]; v = m_valid[i]; yy = m_y[i]; h = hold_of(i);
            if (!rst_n) begin
                t = 0; r = 0; c = 0; s = 0; k = 0; v = 0; yy = 0;
            end else if (s == 1) begin
                yy = t[k / h];
                if (k % h == h - 1) r[k / h] = t[k / h];
                k++;
                if (k == 8 * h) begin s = 2; k = 0; end
            end else begin
                yy = t[in_vec];
                go = (s == 0) && sweep_start && v && !cfg_en;
                if (cfg_en) begin
                    t = {cfg_bit, t[7:1]};
                    c = (c + 1) % 8;
                    v = (c == 0);
                end
                s = go ? 1 : 0;
                if (go) begin k = 0; r = 0; end
            end
            m_tbl[i] <= t; m_res[i] <= r; m_cnt[i] <= c; m_st[i] <= s;
            m_k[i] <= k; m_valid[i] <= v; m_y[i] <= yy;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("y", i, y_o[i], m_y[i]);
                check("cfg_valid", i, valid_o[i], m_valid[i]);
                check("busy", i, busy_o[i], m_st[i] == 1);
                check("done", i, done_o[i], m_st[i] == 2);
                check("idx", i, idx_o[i], (m_st[i] == 1) ? m_k[i] / hold_of(i) : 0);
                check("tt_result", i, res_o[i], m_res[i]);
                check("ones", i, ones_o[i], $countones(m_res[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        for (int r = 0; r < 8; r++) begin
            cfg_en = 1'b1;
            cfg_bit = v[r];
            step();
        end
        cfg_en = 1'b0;
        cfg_bit = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int c, chg;
        logic [2:0] prev;
        step();
        chk_en = 1'b1;
        rst_n = 1'b1;

        for (int r = 0; r < 5; r++) begin
            cfg_en = 1'b1; cfg_bit = 1'b1; step();
        end
        cfg_en = 1'b0;
        pulse_reset();
        check("rst_valid", 0, valid_o, 0);
        check("rst_y", 0, y_o, 0);
        in_vec = 3'd7; step();
        check("rst_tbl_row7", 0, y_o, 0);

        load(8'h96);
        check("xor_valid", 0, valid_o, 2'b11);
        in_vec = 3'b011; step();
        check("xor_y011", 0, y_o, 2'b00);
        in_vec = 3'b111; step();
        check("xor_y111", 0, y_o, 2'b11);

        sweep_start = 1'b1; step(); sweep_start = 1'b0;
        c = 0;
        while (busy_o[0] && c < 50) begin step(); c++; end
        check("xor_busy_cycles", 0, c, 8);
        check("xor_done_pulse", 0, done_o[0], 1);
        step();
        check("xor_done_gone", 0, done_o[0], 0);
        check("xor_tt", 0, res_o[0], 8'h96);
        check("xor_ones", 0, ones_o[0], 4);
        check("model_xor_tt", 0, m_res[0], 8'h96);
        c = 0;
        while (busy_o[1] && c < 50) begin step(); c++; end
        step();
        check("xor_tt", 1, res_o[1], 8'h96);
        check("xor_ones", 1, ones_o[1], 4);

        load(8'hFF);
        sweep_start = 1'b1; step(); sweep_start = 1'b0;
        c = 0; chg = 0; prev = idx_o[1];
        while (busy_o[1] && c < 100) begin
            cfg_en = c[0];
            step();
            c++;
            if (busy_o[1] && idx_o[1] != prev) chg++;
            prev = idx_o[1];
        end
        cfg_en = 1'b0;
        check("ff_busy_cycles", 1, c, 24);
        check("ff_idx_changes", 1, chg, 7);
        check("ff_done_pulse", 1, done_o[1], 1);
        step();
        check("ff_tt", 1, res_o[1], 8'hFF);
        check("ff_ones", 1, ones_o[1], 8);
        check("ff_valid_kept", 1, valid_o[1], 1);
        for (int r = 0; r < 8; r++) begin
            in_vec = 3'(r); step();
            check("ff_tbl_frozen", 1, y_o[1], 1);
        end

        cfg_en = 1'b1; cfg_bit = 1'b0; step(); cfg_en = 1'b0;
        check("inv_valid", 1, valid_o[1], 0);
        sweep_start = 1'b1; step(); sweep_start = 1'b0;
        check("inv_no_busy", 1, busy_o[1], 0);
        step();
        check("inv_no_done", 1, done_o[1], 0);

        pulse_reset();
        load(8'hA5);
        cfg_en = 1'b1; sweep_start = 1'b1; cfg_bit = 1'b1; step();
        cfg_en = 1'b0; sweep_start = 1'b0;
        check("both_no_busy", 0, busy_o, 0);
        check("both_shifted", 0, valid_o, 0);

        pulse_reset();
        load(8'h5A);
        sweep_start = 1'b1; step(); sweep_start = 1'b0;
        step(); step(); step();
        check("mid_busy", 0, busy_o, 2'b11);
        pulse_reset();
        check("midrst_busy", 0, busy_o, 0);
        check("midrst_tt", 0, res_o[0] | res_o[1], 0);
        check("midrst_ones", 0, ones_o[0] | ones_o[1], 0);

        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) load(8'($urandom));
            rst_n = ($urandom_range(149) != 0);
            cfg_en = ($urandom_range(5) == 0);
            cfg_bit = 1'($urandom);
            sweep_start = ($urandom_range(3) == 0);
            in_vec = 3'($urandom);
            step();
        end
        rst_n = 1'b1; cfg_en = 1'b0; sweep_start = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
